bus_initiator: RTL

- CPU-side master for the on-chip synchronous bus (sync/stb/we/wtbt/ack).
- The video register block and other peripherals answer this bus as responders.
- Converts a single-shot request from the CPU core or a DMA source into a correctly sequenced bus cycle.
- Enforces the address-valid → strobe → ack → release ordering, applies a timeout, and reports the captured read data or a bus error.

---
 rtl/bus_initiator.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : bus_initiator
//  Purpose  : CPU/DMA-side master for the on-chip synchronous bus
//             (sync/stb/we/wtbt/ack). Turns a single-shot request into an
//             address-valid -> strobe -> ack -> release sequence, with a
//             strobe timeout and odd-address detection.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_initiator #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_sync,
    output logic        bus_we,
    output logic [1:0]  bus_wtbt,
    output logic        bus_stb,
    input  logic        bus_ack
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR   = 3'd1;
    localparam logic [2:0] c_STROBE = 3'd2;
    localparam logic [2:0] c_HOLD   = 3'd3;
    localparam logic [2:0] c_FIN    = 3'd4;

    // Counter value on the last permitted strobe period.
    localparam logic [9:0] c_CNT_LAST = 10'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [9:0]  r_cnt;
    logic        r_err_pending;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_rdata;
    logic [15:0] r_bus_addr;
    logic [15:0] r_bus_dout;
    logic        r_bus_we;
    logic [1:0]  r_bus_wtbt;

    logic        w_accept;
    logic        w_odd;
    logic        w_cnt_last;
    logic [1:0]  w_wtbt;
    logic [15:0] w_dout;

    assign w_accept   = ce & req;
    assign w_odd      = ~req_byte & req_addr[0];
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // Lane selection for the request being accepted: reads drive no data,
    // byte writes replicate the byte on both lanes.
    always_comb begin
        w_wtbt = 2'b00;
        w_dout = 16'h0000;
        if (req_we) begin
            if (req_byte) begin
                w_wtbt = req_addr[0] ? 2'b10 : 2'b01;
                w_dout = {req_wdata[7:0], req_wdata[7:0]};
            end else begin
                w_wtbt = 2'b11;
                w_dout = req_wdata;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: every phase except FIN waits for a ce cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_next = w_odd ? c_FIN : c_ADDR;
            c_ADDR:   if (ce) w_state_next = c_STROBE;
            c_STROBE: if (ce && (bus_ack || w_cnt_last)) w_state_next = c_HOLD;
            c_HOLD:   if (ce) w_state_next = c_FIN;
            c_FIN:    w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Bus framing and busy follow directly from the phase.
    always_comb begin
        bus_sync = (r_state == c_ADDR) || (r_state == c_STROBE) || (r_state == c_HOLD);
        bus_stb  = (r_state == c_STROBE);
        busy     = (r_state != c_IDLE);
    end

    // Datapath: latch the request, run the strobe timer, capture read data
    // and produce the single-cycle done/err report.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt         <= 10'd0;
            r_err_pending <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= 16'h0000;
            r_bus_addr    <= 16'h0000;
            r_bus_dout    <= 16'h0000;
            r_bus_we      <= 1'b0;
            r_bus_wtbt    <= 2'b00;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_odd) begin
                            // Misaligned word access never reaches the bus.
                            r_err_pending <= 1'b1;
                        end else begin
                            r_err_pending <= 1'b0;
                            r_bus_addr    <= req_addr;
                            r_bus_dout    <= w_dout;
                            r_bus_we      <= req_we;
                            r_bus_wtbt    <= w_wtbt;
                        end
                    end
                end
                c_ADDR: begin
                    if (ce) r_cnt <= 10'd0;
                end
                c_STROBE: begin
                    if (ce) begin
                        if (bus_ack) begin
                            if (!r_bus_we) r_rdata <= bus_din;
                            r_err_pending <= 1'b0;
                        end else if (w_cnt_last) begin
                            r_err_pending <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end
                end
                c_HOLD: begin
                    if (ce) begin
                        r_bus_we   <= 1'b0;
                        r_bus_wtbt <= 2'b00;
                    end
                end
                c_FIN: begin
                    r_done <= 1'b1;
                    r_err  <= r_err_pending;
                end
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign bus_addr = r_bus_addr;
    assign bus_dout = r_bus_dout;
    assign bus_we   = r_bus_we;
    assign bus_wtbt = r_bus_wtbt;

endmodule
`default_nettype wire
